// File: rtl/cpu_pkg.sv
// Shared types and width constants for the multi-cycle CPU sequencer.
package cpu_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Instruction opcodes, IR[15:13].
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_SUB  = 3'd2,
    OP_NAND = 3'd3,
    OP_BNE  = 3'd4,
    OP_LW   = 3'd5,
    OP_SW   = 3'd6,
    OP_J    = 3'd7
  } opcode_e;

  // Sequencer states kept as plain constants so the encoding stays fixed.
  typedef logic [2:0] seq_state_e;
  localparam seq_state_e S_FETCH_SETUP  = 3'd0;
  localparam seq_state_e S_FETCH_ACCESS = 3'd1;
  localparam seq_state_e S_DECODE       = 3'd2;
  localparam seq_state_e S_EXEC         = 3'd3;
  localparam seq_state_e S_MEM_SETUP    = 3'd4;
  localparam seq_state_e S_MEM_ACCESS   = 3'd5;
  localparam seq_state_e S_WRITEBACK    = 3'd6;
  localparam seq_state_e S_FAULT        = 3'd7;

  // Next-PC source select driven to the datapath.
  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// APB bus bundle between the sequencer (master) and memory (slave).
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/cpu_apb_master.sv
// APB phasing for the sequencer: drives SETUP/ACCESS, holds address and
// data steady across wait states, and reports completion or error.
// Optional access watchdog enabled by defining APB_TIMEOUT_EN.
module cpu_apb_master
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setup,
  input  logic              access,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  cpu_sequencer_if.master   apb
);

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_sel;
  logic              timeout;

  assign wdata_sel = wr ? wdata : '0;

  // Capture the transfer attributes in SETUP so they hold through ACCESS.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (setup) begin
      wr_q    <= wr;
      addr_q  <= addr;
      wdata_q <= wdata_sel;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Count ACCESS cycles without pready; every new SETUP restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (setup) begin
      wait_cnt <= '0;
    end else if (access && !apb.pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The ACCESS cycle that would bring the count to TIMEOUT_CYC aborts the transfer.
  assign timeout = access && !apb.pready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // The SETUP cycle presents the live request; later cycles replay the held copy.
  assign apb.psel    = setup | access;
  assign apb.penable = access;
  assign apb.pwrite  = setup ? wr : (access & wr_q);
  assign apb.paddr   = setup ? addr : addr_q;
  assign apb.pwdata  = setup ? wdata_sel : wdata_q;

  assign done  = access && apb.pready && !apb.pslverr;
  assign err   = (access && apb.pready && apb.pslverr) || timeout;
  assign rdata = apb.prdata;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit, 8-opcode CPU. Shares one APB
// master between instruction fetch and LW/SW, and strobes IR/PC/RF updates.
// Optional APB access watchdog enabled by defining APB_TIMEOUT_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              ne_flag,
  cpu_sequencer_if.master   apb,
  output logic              ir_load,
  output logic [DATA_W-1:0] fetch_data,
  output logic              pc_load,
  output logic [1:0]        pc_sel,
  output logic              rf_we,
  output logic              rf_wsel,
  output logic              fault
);

  seq_state_e        state, state_nxt;
  logic              live;
  opcode_e           op_q;
  logic              taken_q;
  logic [DATA_W-1:0] mdr_q;
  pc_sel_e           sel;

  logic              bus_setup, bus_access, bus_wr, bus_done, bus_err, rd_done;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_rdata;

  // live is low for the first cycle after reset so the bus stays idle
  // while reset is held and starts fetching on the first clock after release.
  assign bus_setup  = (state == S_FETCH_SETUP && live) || state == S_MEM_SETUP;
  assign bus_access = state == S_FETCH_ACCESS || state == S_MEM_ACCESS;
  assign bus_wr     = state == S_MEM_SETUP && op_q == OP_SW;
  assign bus_addr   = (state == S_MEM_SETUP) ? ADDR_W'(alu_result) : pc;

  cpu_apb_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_apb (
    .clk    (clk),
    .reset  (reset),
    .setup  (bus_setup),
    .access (bus_access),
    .wr     (bus_wr),
    .addr   (bus_addr),
    .wdata  (store_data),
    .done   (bus_done),
    .err    (bus_err),
    .rdata  (bus_rdata),
    .apb    (apb)
  );

  // Next-state selection.
  // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH_SETUP:  if (live) state_nxt = S_FETCH_ACCESS;
      S_FETCH_ACCESS: begin
        if (bus_err)       state_nxt = S_FAULT;
        else if (bus_done) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (opcode_e'(opcode))
          OP_BNE, OP_J:  state_nxt = S_EXEC;
          OP_LW, OP_SW:  state_nxt = S_MEM_SETUP;
          default:       state_nxt = S_WRITEBACK;
        endcase
      end
      S_EXEC:         state_nxt = S_FETCH_SETUP;
      S_MEM_SETUP:    state_nxt = S_MEM_ACCESS;
      S_MEM_ACCESS: begin
        if (bus_err)       state_nxt = S_FAULT;
        else if (bus_done) state_nxt = (op_q == OP_LW) ? S_WRITEBACK : S_FETCH_SETUP;
      end
      S_WRITEBACK:    state_nxt = S_FETCH_SETUP;
      S_FAULT:        state_nxt = S_FAULT;
      default:        state_nxt = S_FAULT;
    endcase
  end

  // State, decoded opcode/branch outcome, and the memory data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH_SETUP;
      live    <= 1'b0;
      op_q    <= OP_ADD;
      taken_q <= 1'b0;
      mdr_q   <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (state == S_DECODE) begin
        op_q    <= opcode_e'(opcode);
        taken_q <= ne_flag;
      end
      if (rd_done) mdr_q <= bus_rdata;
    end
  end

  // Next-PC source: only EXEC redirects, everything else steps by one.
  always_comb begin
    sel = PC_INC;
    if (state == S_EXEC) begin
      if (op_q == OP_J)  sel = PC_JMP;
      else if (taken_q)  sel = PC_BR;
    end
  end

  // SW completions carry no read data, so they leave the MDR untouched.
  assign rd_done = bus_done && !(state == S_MEM_ACCESS && op_q == OP_SW);

  // On the completing cycle prdata is forwarded so IR/RF can load it on the same edge.
  assign fetch_data = rd_done ? bus_rdata : mdr_q;
  assign ir_load    = state == S_FETCH_ACCESS && bus_done;
  assign pc_load    = state == S_EXEC || state == S_WRITEBACK ||
                      (state == S_MEM_ACCESS && op_q == OP_SW && bus_done);
  assign pc_sel     = sel;
  assign rf_we      = state == S_WRITEBACK;
  assign rf_wsel    = state == S_WRITEBACK && op_q == OP_LW;
  assign fault      = state == S_FAULT;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one instruction per scenario against a
// small APB memory with configurable data-access wait states and errors.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  opcode;
  logic [15:0] pc_v, alu_result, store_data;
  logic        ne_flag;
  logic        ir_load, pc_load, rf_we, rf_wsel, fault;
  logic [15:0] fetch_data;
  logic [1:0]  pc_sel;

  cpu_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cpu_sequencer #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .pc         (pc_v),
    .alu_result (alu_result),
    .store_data (store_data),
    .ne_flag    (ne_flag),
    .apb        (bus),
    .ir_load    (ir_load),
    .fetch_data (fetch_data),
    .pc_load    (pc_load),
    .pc_sel     (pc_sel),
    .rf_we      (rf_we),
    .rf_wsel    (rf_wsel),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Memory model: fetches (paddr == pc) are zero-wait; data accesses take mem_waits.
  logic [15:0] instr_word, mem_word;
  int          mem_waits;
  bit          err_en, hang;
  int          wait_cnt = 0;
  logic        data_acc;

  assign data_acc    = (bus.paddr != pc_v);
  assign bus.prdata  = data_acc ? mem_word : instr_word;
  assign bus.pslverr = err_en && data_acc;

  always_comb begin
    bus.pready = 1'b0;
    if (bus.psel && bus.penable) begin
      if (!data_acc)  bus.pready = 1'b1;
      else if (!hang) bus.pready = (wait_cnt >= mem_waits);
    end
  end

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready) wait_cnt <= wait_cnt + 1;
    else                                        wait_cnt <= 0;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-instruction observations.
  int          cyc, ir_cyc, rfwe_cyc, rfwe_n, pcl_n, hold_bad, acc_n;
  int          coinc = 0;
  logic [1:0]  sel_seen;
  logic        wsel_seen, m_wr;
  logic [15:0] ir_data, m_addr, m_wdata;
  bit          flip_ne;

  // Runs from a FETCH_SETUP sample until pc_load or fault (bounded), then steps once.
  task automatic run_instr();
    cyc = 0; ir_cyc = 0; rfwe_cyc = 0; rfwe_n = 0; pcl_n = 0; hold_bad = 0; acc_n = 0;
    sel_seen = 2'b11; wsel_seen = 1'b0; m_wr = 1'b0; ir_data = '0; m_addr = '0; m_wdata = '0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 4 && flip_ne) begin
        ne_flag = !ne_flag;
        #1;
      end
      if (ir_load) begin
        ir_cyc  = n;
        ir_data = fetch_data;
      end
      if (ir_load && (pc_load || rf_we)) coinc++;
      if (rf_we) begin
        rfwe_n++;
        rfwe_cyc  = n;
        wsel_seen = rf_wsel;
      end
      if (pc_load) begin
        pcl_n++;
        sel_seen = pc_sel;
      end
      if (bus.psel && data_acc) begin
        if (!bus.penable) begin
          m_addr  = bus.paddr;
          m_wr    = bus.pwrite;
          m_wdata = bus.pwdata;
        end else begin
          acc_n++;
          if (bus.paddr != m_addr || bus.pwrite != m_wr || bus.pwdata != m_wdata) hold_bad++;
          if (acc_n == 1) begin
            alu_result = ~alu_result;
            store_data = ~store_data;
          end
        end
      end
      if (pc_load || fault) begin
        cyc = n;
        step();
        return;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int quiet_bad, sticky_bad, found;

  initial begin
    reset = 1'b0; opcode = OP_ADD; pc_v = 16'h0000; alu_result = '0; store_data = '0;
    ne_flag = 1'b0; instr_word = 16'h0123; mem_word = '0; mem_waits = 0;
    err_en = 1'b0; hang = 1'b0; flip_ne = 1'b0;

    // Reset state.
    #12;
    check("rst_psel",    bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite",  bus.pwrite, 0);
    check("rst_paddr",   bus.paddr, 0);
    check("rst_pwdata",  bus.pwdata, 0);
    check("rst_strobes", {ir_load, pc_load, rf_we, rf_wsel, fault}, 0);
    check("rst_pc_sel",  pc_sel, 0);
    check("rst_fdata",   fetch_data, 0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_psel_idle", bus.psel, 0);
    step();
    check("c1_psel",    bus.psel, 1);
    check("c1_penable", bus.penable, 0);
    check("c1_paddr",   bus.paddr, 16'h0000);

    // ADD at 0x0000, zero waits.
    run_instr();
    check("add_cycles", cyc, 4);
    check("add_ir_cyc", ir_cyc, 2);
    check("add_ir_data", ir_data, 16'h0123);
    check("add_rfwe_cyc", rfwe_cyc, 4);
    check("add_rfwe_n", rfwe_n, 1);
    check("add_sel", sel_seen, PC_INC);
    check("add_wsel", wsel_seen, 0);

    // LW at 0x0010 from 0x0100, two data wait states.
    pc_v = 16'h0010; instr_word = 16'hA1B2; opcode = OP_LW;
    alu_result = 16'h0100; mem_word = 16'hBEEF; mem_waits = 2;
    run_instr();
    check("lw_cycles", cyc, 8);
    check("lw_ir_data", ir_data, 16'hA1B2);
    check("lw_paddr", m_addr, 16'h0100);
    check("lw_pwrite", m_wr, 0);
    check("lw_access_n", acc_n, 3);
    check("lw_hold", hold_bad, 0);
    check("lw_fdata", fetch_data, 16'hBEEF);
    check("lw_rfwe_n", rfwe_n, 1);
    check("lw_wsel", wsel_seen, 1);
    check("lw_sel", sel_seen, PC_INC);

    // SW of 0x1234 to 0x0200, two data wait states.
    pc_v = 16'h0020; instr_word = 16'hC3C3; opcode = OP_SW;
    alu_result = 16'h0200; store_data = 16'h1234; mem_word = 16'hDEAD; mem_waits = 2;
    run_instr();
    check("sw_cycles", cyc, 7);
    check("sw_paddr", m_addr, 16'h0200);
    check("sw_pwrite", m_wr, 1);
    check("sw_pwdata", m_wdata, 16'h1234);
    check("sw_hold", hold_bad, 0);
    check("sw_rfwe_n", rfwe_n, 0);
    check("sw_pcl_n", pcl_n, 1);
    check("sw_sel", sel_seen, PC_INC);
    check("sw_fdata", fetch_data, 16'hC3C3);

    // BNE taken / not taken (ne_flag flipped after DECODE), then J.
    mem_waits = 0;
    pc_v = 16'h0030; opcode = OP_BNE; ne_flag = 1'b1; flip_ne = 1'b1;
    run_instr();
    check("bne_t_cycles", cyc, 4);
    check("bne_t_sel", sel_seen, PC_BR);
    pc_v = 16'h0031; ne_flag = 1'b0;
    run_instr();
    check("bne_n_cycles", cyc, 4);
    check("bne_n_sel", sel_seen, PC_INC);
    flip_ne = 1'b0;
    pc_v = 16'h0032; opcode = OP_J;
    run_instr();
    check("j_cycles", cyc, 4);
    check("j_sel", sel_seen, PC_JMP);
    check("j_rfwe_n", rfwe_n, 0);

    // PC at the top of the address space fetches like any other.
    pc_v = 16'hFFFF; opcode = OP_NAND;
    run_instr();
    check("wrap_cycles", cyc, 4);
    check("wrap_sel", sel_seen, PC_INC);

    // Slave error on the LW data access: sticky fault.
    pc_v = 16'h0040; opcode = OP_LW; alu_result = 16'h0300; err_en = 1'b1; mem_waits = 1;
    run_instr();
    check("err_cycles", cyc, 7);
    check("err_rfwe_n", rfwe_n, 0);
    check("err_pcl_n", pcl_n, 0);
    quiet_bad = 0; sticky_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.psel || ir_load || pc_load || rf_we) quiet_bad++;
      if (!fault) sticky_bad++;
      step();
    end
    check("fault_quiet", quiet_bad, 0);
    check("fault_sticky", sticky_bad, 0);
    reset = 1'b0;
    #1;
    check("fault_cleared", fault, 0);
    err_en = 1'b0;

    // Reset asserted in the middle of a SW data access.
    pc_v = 16'h0050; opcode = OP_SW; alu_result = 16'h0400; store_data = 16'h5555; mem_waits = 5;
    @(negedge clk);
    reset = 1'b1;
    step();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.psel && bus.penable && data_acc) begin
        found = 1;
        break;
      end
      step();
    end
    check("mid_found", found, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_psel", bus.psel, 0);
    check("mid_penable", bus.penable, 0);
    check("mid_bus", {bus.pwrite, bus.paddr, bus.pwdata}, 0);
    check("mid_strobes", {ir_load, pc_load, rf_we, fault}, 0);
    pc_v = 16'h0060; opcode = OP_ADD;
    @(negedge clk);
    reset = 1'b1;
    step();
    check("restart_psel", {bus.psel, bus.penable}, 2'b10);
    check("restart_paddr", bus.paddr, 16'h0060);
    run_instr();
    check("restart_cycles", cyc, 4);

`ifdef APB_TIMEOUT_EN
    // Slave never answers the data access: watchdog after four access cycles.
    pc_v = 16'h0070; opcode = OP_LW; alu_result = 16'h0500; hang = 1'b1;
    run_instr();
    check("to_cycles", cyc, 9);
    check("to_access_n", acc_n, 4);
    check("to_fault", {fault, bus.psel}, 2'b10);
    reset = 1'b0;
    hang = 1'b0;
    #1;
    check("to_cleared", fault, 0);
`endif

    check("ir_pc_rf_exclusive", coinc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
